fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value after reset.
REQ-002 Parameter TIMEOUT, default 8'd15: max cycles mem_req may wait for mem_ack before fault.
REQ-003 clock  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 ir_load  input  1  fetch request from control unit (asserted in its FETCH state).
REQ-006 pc_load  input  1  load PC with pc_target.
REQ-007 pc_target  input  16  branch/jump target address.
REQ-008 mem_ack  input  1  memory read data valid.
REQ-009 mem_rdata  input  8  memory read data (opcode byte).
REQ-010 mem_req  output  1  memory read request, registered.
REQ-011 mem_addr  output  16  memory read address, registered.
REQ-012 ir  output  8  instruction register, feeds control unit IR input.
REQ-013 ir_valid  output  1  one-cycle pulse: ir updated this cycle.
REQ-014 busy  output  1  high in REQUEST and FAULT states.
REQ-015 pc  output  16  current program counter.
REQ-016 fault  output  1  sticky memory-timeout flag.

Function
REQ-017 FSM states IDLE, REQUEST, FAULT; reset state IDLE.
REQ-018 IDLE, pc_load=1: pc <= pc_target at the edge.
REQ-019 IDLE, ir_load=1, pc_load=0: next state REQUEST, mem_req <= 1, mem_addr <= pc.
REQ-020 IDLE, ir_load=1 and pc_load=1 same edge: mem_addr <= pc_target, pc <= pc_target, state REQUEST.
REQ-021 REQUEST: mem_req and mem_addr held stable until mem_ack sampled high or timeout.
REQ-022 REQUEST, mem_ack=1 at edge: ir <= mem_rdata, pc <= mem_addr + 1 (mod 2^16, 16'hFFFF wraps to 16'h0000), ir_valid <= 1 for exactly one cycle, mem_req <= 0, state IDLE.
REQ-023 Minimum latency: ir_load sampled at edge N, mem_ack high before edge N+1 -> ir_valid high in cycle after edge N+1.
REQ-024 mem_ack ignored whenever mem_req=0.
REQ-025 ir_load ignored while busy=1; no request queuing.
REQ-026 pc_load during REQUEST: target latched as pending; on completion pc <= pending target instead of mem_addr+1; last pc_load wins.
REQ-027 Wait counter: cleared on entry to REQUEST, increments each edge in REQUEST with mem_ack=0.
REQ-028 Wait counter reaching TIMEOUT with mem_ack=0: state FAULT, mem_req <= 0, fault <= 1, ir and pc unchanged, no ir_valid.
REQ-029 mem_ack=1 on the same edge the counter reaches TIMEOUT: ack wins, normal completion.
REQ-030 FAULT: absorbing until reset; ir_load and pc_load ignored; busy=1.
REQ-031 ir holds its value between fetches; ir_valid=0 outside completion cycle.

Reset
REQ-032 reset low asynchronously forces: state IDLE, pc=RESET_PC, ir=8'h00, mem_addr=16'h0000, mem_req=0, ir_valid=0, fault=0, wait counter 0, pending pc_load cleared.
REQ-033 reset during REQUEST drops mem_req immediately (combinationally with reset assertion via async flop clear); late mem_ack after release ignored.

Structure
REQ-034 Shared package holds: fetch state enum, ADDR_W=16, OPCODE_W=8, opcode constants shared with the control unit.
REQ-035 One sub-module natural: fetch_wait_timer (clear/enable/expired, width from TIMEOUT); all else in fetch_unit.

Verification
REQ-036 Reset release, ir_load pulse, mem_ack next cycle with rdata=8'h05 -> mem_addr=16'h0000, ir=8'h05, ir_valid one cycle, pc=16'h0001.
REQ-037 pc_load with pc_target=16'hFFFF in IDLE, then fetch, ack rdata=8'h0B -> mem_addr=16'hFFFF, ir=8'h0B, pc=16'h0000.
REQ-038 ack delayed 3 cycles, ir_load re-pulsed during wait -> single request, mem_addr stable, one ir_valid pulse.
REQ-039 pc_load pc_target=16'h1234 during REQUEST at pc=16'h0010 -> after ack pc=16'h1234, not 16'h0011.
REQ-040 No ack for 15 cycles -> fault=1, mem_req=0, busy=1; further ir_load ignored; reset clears fault; ack on 15th edge -> normal completion, fault=0.
REQ-041 Assert reset mid-REQUEST -> mem_req=0 before next edge, pc=RESET_PC, ir=8'h00.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control unit that consumes its IR.
package fetch_unit_pkg;

   localparam int ADDR_W   = 16;
   localparam int OPCODE_W = 8;

   // Opcode byte values the control unit decodes from ir.
   localparam logic [OPCODE_W-1:0] OP_NOP = 8'h00;
   localparam logic [OPCODE_W-1:0] OP_LDA = 8'h05;
   localparam logic [OPCODE_W-1:0] OP_STA = 8'h06;
   localparam logic [OPCODE_W-1:0] OP_ADD = 8'h08;
   localparam logic [OPCODE_W-1:0] OP_JMP = 8'h0B;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 8'h0C;
   localparam logic [OPCODE_W-1:0] OP_HLT = 8'hFF;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'd0,
      FS_REQUEST = 2'd1,
      FS_FAULT   = 2'd2
   } fetch_state_e;

   // Sequential successor of a fetch address; wraps from 16'hFFFF to 16'h0000.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
      return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts edges spent waiting for mem_ack; flags the edge on which the count reaches TIMEOUT.
module fetch_wait_timer
   import fetch_unit_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(int'(TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 8'd1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over enable; count saturates at TIMEOUT.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_MAX)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Wait count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // High when the next enabled edge brings the count to TIMEOUT.
   assign expired = enable && (count_q == CNT_LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one registered memory read per fetch
// request, loads the opcode byte into ir, and latches a sticky timeout fault.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// FS_IDLE    | no read outstanding; accepts pc_load and ir_load
// FS_REQUEST | mem_req high, waiting for mem_ack; pc_load is held as pending
// FS_FAULT   | memory timed out; absorbing until reset, all requests ignored
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [7:0]  TIMEOUT  = 8'd15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ir_load,
   input  logic                pc_load,
   input  logic [ADDR_W-1:0]   pc_target,
   input  logic                mem_ack,
   input  logic [OPCODE_W-1:0] mem_rdata,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [OPCODE_W-1:0] ir,
   output logic                ir_valid,
   output logic                busy,
   output logic [ADDR_W-1:0]   pc,
   output logic                fault
);

   fetch_state_e        state_q,    state_d;
   logic [ADDR_W-1:0]   pc_q,       pc_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [OPCODE_W-1:0] ir_q,       ir_d;
   logic                req_q,      req_d;
   logic                valid_q,    valid_d;
   logic                fault_q,    fault_d;
   logic                pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0]   pend_pc_q,  pend_pc_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   fetch_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Next-state and datapath updates; mem_ack is only looked at in FS_REQUEST,
   // which is exactly when mem_req is high.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      ir_d         = ir_q;
      req_d        = req_q;
      valid_d      = 1'b0;
      fault_d      = fault_q;
      pend_vld_d   = pend_vld_q;
      pend_pc_d    = pend_pc_q;
      timer_clear  = 1'b0;
      timer_enable = 1'b0;

      unique case (state_q)
         FS_IDLE: begin
            if (pc_load) begin
               pc_d = pc_target;
            end
            if (ir_load) begin
               state_d     = FS_REQUEST;
               req_d       = 1'b1;
               addr_d      = pc_load ? pc_target : pc_q;
               pend_vld_d  = 1'b0;
               timer_clear = 1'b1;
            end
         end

         FS_REQUEST: begin
            if (pc_load) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = pc_target;
            end
            if (mem_ack) begin
               // A pc_load on the completion edge is the most recent one.
               if (pc_load) begin
                  pc_d = pc_target;
               end else if (pend_vld_q) begin
                  pc_d = pend_pc_q;
               end else begin
                  pc_d = next_pc(addr_q);
               end
               ir_d       = mem_rdata;
               valid_d    = 1'b1;
               req_d      = 1'b0;
               pend_vld_d = 1'b0;
               state_d    = FS_IDLE;
            end else begin
               timer_enable = 1'b1;
               if (timer_expired) begin
                  state_d    = FS_FAULT;
                  req_d      = 1'b0;
                  fault_d    = 1'b1;
                  pend_vld_d = 1'b0;
               end
            end
         end

         FS_FAULT: begin
            req_d = 1'b0;
         end

         default: begin
            state_d = FS_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset clears mem_req asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= '0;
         ir_q       <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign ir       = ir_q;
   assign ir_valid = valid_q;
   assign pc       = pc_q;
   assign fault    = fault_q;
   assign busy     = (state_q == FS_REQUEST) || (state_q == FS_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        ir_load;
   logic        pc_load;
   logic [15:0] pc_target;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  ir;
   logic        ir_valid;
   logic        busy;
   logic [15:0] pc;
   logic        fault;

   int errors = 0;
   int checks = 0;

   fetch_unit #(
      .RESET_PC (16'h0000),
      .TIMEOUT  (8'd15)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ir_load   (ir_load),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .busy      (busy),
      .pc        (pc),
      .fault     (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   // One full cycle: passes the rising edge, returns on the next falling edge.
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0; ir_load = 1'b0; pc_load = 1'b0; pc_target = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      #2;
      checks++; if (pc !== 16'h0000)   begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
      checks++; if (ir !== 8'h00)      begin errors++; $display("FAIL reset_ir got %h want 00", ir); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
      checks++; if ({mem_req, ir_valid, busy, fault} !== 4'b0000)
         begin errors++; $display("FAIL reset_flags got %b want 0000", {mem_req, ir_valid, busy, fault}); end
      @(negedge clock);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if ({mem_req, busy, ir_valid} !== 3'b110) begin errors++; $display("FAIL basic_req got %b want 110", {mem_req, busy, ir_valid}); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL basic_addr got %h want 0000", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h05;
      tick();
      mem_ack = 1'b0; mem_rdata = 8'hEE;
      checks++; if (ir !== 8'h05) begin errors++; $display("FAIL basic_ir got %h want 05", ir); end
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", ir_valid); end
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL basic_pc got %h want 0001", pc); end
      checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL basic_done got %b want 00", {mem_req, busy}); end
      tick();
      checks++; if ({ir_valid, ir} !== {1'b0, 8'h05}) begin errors++; $display("FAIL basic_hold got %b/%h want 0/05", ir_valid, ir); end
   endtask

   task automatic test_wrap();
      pc_load = 1'b1; pc_target = 16'hFFFF;
      tick();
      pc_load = 1'b0;
      checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_load got %h want FFFF", pc); end
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got %h want FFFF", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h0B;
      tick();
      mem_ack = 1'b0;
      checks++; if ({ir, pc} !== {8'h0B, 16'h0000}) begin errors++; $display("FAIL wrap_done got %h/%h want 0B/0000", ir, pc); end
   endtask

   task automatic test_load_and_fetch();
      ir_load = 1'b1; pc_load = 1'b1; pc_target = 16'h0200;
      tick();
      ir_load = 1'b0; pc_load = 1'b0;
      checks++; if ({mem_addr, pc} !== {16'h0200, 16'h0200}) begin errors++; $display("FAIL combo_addr got %h/%h want 0200/0200", mem_addr, pc); end
      mem_ack = 1'b1; mem_rdata = 8'h08;
      tick();
      mem_ack = 1'b0;
      checks++; if ({ir, pc} !== {8'h08, 16'h0201}) begin errors++; $display("FAIL combo_done got %h/%h want 08/0201", ir, pc); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int reqs_ok;
      pulses = 0; reqs_ok = 0;
      pc_load = 1'b1; pc_target = 16'h0040;
      tick();
      pc_load = 1'b0;
      ir_load = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         ir_load = (i != 1);
         tick();
         if (ir_valid) pulses++;
         if (mem_req === 1'b1 && mem_addr === 16'h0040) reqs_ok++;
      end
      ir_load = 1'b0;
      checks++; if (reqs_ok !== 3) begin errors++; $display("FAIL b2b_stable got %0d want 3", reqs_ok); end
      mem_ack = 1'b1; mem_rdata = 8'h06;
      tick();
      mem_ack = 1'b0;
      if (ir_valid) pulses++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ir_valid) pulses++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
      checks++; if ({mem_req, pc, ir} !== {1'b0, 16'h0041, 8'h06}) begin errors++; $display("FAIL b2b_end got %b/%h/%h want 0/0041/06", mem_req, pc, ir); end
   endtask

   task automatic test_pending_load();
      pc_load = 1'b1; pc_target = 16'h0010;
      tick();
      pc_load = 1'b0; ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL pend_addr got %h want 0010", mem_addr); end
      pc_load = 1'b1; pc_target = 16'h5555;
      tick();
      pc_target = 16'h1234;
      tick();
      pc_load = 1'b0;
      checks++; if ({pc, mem_addr} !== {16'h0010, 16'h0010}) begin errors++; $display("FAIL pend_hold got %h/%h want 0010/0010", pc, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h3C;
      tick();
      mem_ack = 1'b0;
      checks++; if ({pc, ir} !== {16'h1234, 8'h3C}) begin errors++; $display("FAIL pend_pc got %h/%h want 1234/3C", pc, ir); end
   endtask

   task automatic test_timeout();
      int early_fault;
      early_fault = 0;
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      for (int i = 1; i < 15; i++) begin
         tick();
         if (fault !== 1'b0 || mem_req !== 1'b1) early_fault++;
      end
      checks++; if (early_fault !== 0) begin errors++; $display("FAIL tmo_early got %0d want 0", early_fault); end
      tick();
      checks++; if ({fault, mem_req, busy, ir_valid} !== 4'b1010) begin errors++; $display("FAIL tmo_fault got %b want 1010", {fault, mem_req, busy, ir_valid}); end
      checks++; if ({pc, ir} !== {16'h1234, 8'h3C}) begin errors++; $display("FAIL tmo_keep got %h/%h want 1234/3C", pc, ir); end
      ir_load = 1'b1; pc_load = 1'b1; pc_target = 16'h7777; mem_ack = 1'b1; mem_rdata = 8'h99;
      tick(); tick();
      ir_load = 1'b0; pc_load = 1'b0; mem_ack = 1'b0;
      checks++; if ({fault, mem_req, busy, ir_valid, pc, ir} !== {4'b1010, 16'h1234, 8'h3C})
         begin errors++; $display("FAIL tmo_absorb got %b%b%b%b/%h/%h want 1010/1234/3C", fault, mem_req, busy, ir_valid, pc, ir); end
      reset = 1'b0;
      #1;
      checks++; if ({fault, busy, pc} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL tmo_reset got %b%b/%h want 00/0000", fault, busy, pc); end
      tick();
      reset = 1'b1;
      tick();
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      mem_ack = 1'b1; mem_rdata = 8'h22;
      tick();
      mem_ack = 1'b0;
      checks++; if ({fault, ir_valid, ir, pc} !== {2'b01, 8'h22, 16'h0001})
         begin errors++; $display("FAIL tmo_lastack got %b%b/%h/%h want 01/22/0001", fault, ir_valid, ir, pc); end
   endtask

   task automatic test_reset_mid();
      pc_load = 1'b1; pc_target = 16'h0300;
      tick();
      pc_load = 1'b0; ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0300}) begin errors++; $display("FAIL mid_req got %b/%h want 1/0300", mem_req, mem_addr); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if ({mem_req, busy, pc, ir} !== {2'b00, 16'h0000, 8'h00})
         begin errors++; $display("FAIL mid_reset got %b%b/%h/%h want 00/0000/00", mem_req, busy, pc, ir); end
      tick();
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hAB;
      tick(); tick();
      mem_ack = 1'b0;
      checks++; if ({ir_valid, ir, pc, mem_req} !== {1'b0, 8'h00, 16'h0000, 1'b0})
         begin errors++; $display("FAIL mid_lateack got %b/%h/%h/%b want 0/00/0000/0", ir_valid, ir, pc, mem_req); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_load_and_fetch();
      test_back_to_back();
      test_pending_load();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
